// File: rtl/tmds_channel_decoder.sv
// Receive-side TMDS channel decoder: bit-boundary search on control tokens,
// 8b/10b data and 2b control decode, and lock tracking in the pixel clock domain.
module tmds_channel_decoder #(
    parameter int search_window = 1024,
    parameter int lock_run      = 8,
    parameter int lost_timeout  = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] symbol_in,
    output logic [7:0] data,
    output logic [1:0] ctrl,
    output logic       de,
    output logic       locked,
    output logic [3:0] offset
);

    localparam int WIN_W = (search_window > 2) ? $clog2(search_window) : 1;
    localparam int RUN_W = $clog2(lock_run + 1);
    localparam int TMO_W = (lost_timeout > 2) ? $clog2(lost_timeout) : 1;

    typedef enum logic {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // Returns {is_token, c1, c0}; all-zero for a data symbol.
    function automatic logic [2:0] tok_lookup(input logic [9:0] q);
        case (q)
            10'b1101010100: return {1'b1, 2'b00};
            10'b0010101011: return {1'b1, 2'b01};
            10'b0101010100: return {1'b1, 2'b10};
            10'b1010101011: return {1'b1, 2'b11};
            default:        return 3'b000;
        endcase
    endfunction

    function automatic logic [7:0] tmds_data(input logic [9:0] q);
        logic [7:0] d;
        logic [7:0] o;
        d    = q[9] ? ~q[7:0] : q[7:0];
        o    = 8'h00;
        o[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            o[i] = q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
        return o;
    endfunction

    state_t           r_state;
    state_t           w_state_nxt;
    logic [9:0]       r_raw;
    logic [9:0]       r_aligned;
    logic [3:0]       r_offset;
    logic [RUN_W-1:0] r_run;
    logic [WIN_W-1:0] r_win;
    logic [TMO_W-1:0] r_tmo;
    logic [7:0]       r_data;
    logic [1:0]       r_ctrl;
    logic             r_de;
    logic             r_locked;

    logic [19:0]      w_window;
    logic [9:0]       w_aligned_nxt;
    logic [2:0]       w_tok;
    logic             w_is_tok;
    logic [7:0]       w_dec;
    logic [3:0]       w_offset_nxt;
    logic [RUN_W-1:0] w_run_nxt;
    logic [WIN_W-1:0] w_win_nxt;
    logic [TMO_W-1:0] w_tmo_nxt;

    assign w_window = {symbol_in, r_raw};
    assign w_tok    = tok_lookup(r_aligned);
    assign w_is_tok = w_tok[2];
    assign w_dec    = tmds_data(r_aligned);

    // Bit-offset mux: older word supplies bits offset..9, newer word the rest.
    always_comb begin
        w_aligned_nxt = r_raw;
        case (r_offset)
            4'd0:    w_aligned_nxt = w_window[9:0];
            4'd1:    w_aligned_nxt = w_window[10:1];
            4'd2:    w_aligned_nxt = w_window[11:2];
            4'd3:    w_aligned_nxt = w_window[12:3];
            4'd4:    w_aligned_nxt = w_window[13:4];
            4'd5:    w_aligned_nxt = w_window[14:5];
            4'd6:    w_aligned_nxt = w_window[15:6];
            4'd7:    w_aligned_nxt = w_window[16:7];
            4'd8:    w_aligned_nxt = w_window[17:8];
            4'd9:    w_aligned_nxt = w_window[18:9];
            default: w_aligned_nxt = r_raw;
        endcase
    end

    // Next-state logic: lock on a token run, otherwise slide offset at window expiry.
    always_comb begin
        w_state_nxt  = r_state;
        w_offset_nxt = r_offset;
        w_run_nxt    = r_run;
        w_win_nxt    = r_win;
        w_tmo_nxt    = r_tmo;
        case (r_state)
            ST_SEARCH: begin
                w_tmo_nxt = '0;
                if (w_is_tok && (r_run == RUN_W'(lock_run - 1))) begin
                    w_state_nxt = ST_LOCKED;
                    w_run_nxt   = '0;
                    w_win_nxt   = '0;
                end else if (r_win == WIN_W'(search_window - 1)) begin
                    w_offset_nxt = (r_offset == 4'd9) ? 4'd0 : (r_offset + 4'd1);
                    w_run_nxt    = '0;
                    w_win_nxt    = '0;
                end else begin
                    w_win_nxt = r_win + WIN_W'(1);
                    w_run_nxt = w_is_tok ? (r_run + RUN_W'(1)) : RUN_W'(0);
                end
            end
            ST_LOCKED: begin
                if (w_is_tok) begin
                    w_tmo_nxt = '0;
                end else if (r_tmo == TMO_W'(lost_timeout - 1)) begin
                    w_state_nxt = ST_SEARCH;
                    w_tmo_nxt   = '0;
                    w_run_nxt   = '0;
                    w_win_nxt   = '0;
                end else begin
                    w_tmo_nxt = r_tmo + TMO_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_SEARCH;
                w_run_nxt   = '0;
                w_win_nxt   = '0;
                w_tmo_nxt   = '0;
            end
        endcase
    end

    // State, counters and alignment pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_SEARCH;
            r_raw     <= 10'd0;
            r_aligned <= 10'd0;
            r_offset  <= 4'd0;
            r_run     <= '0;
            r_win     <= '0;
            r_tmo     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_raw     <= symbol_in;
            r_aligned <= w_aligned_nxt;
            r_offset  <= w_offset_nxt;
            r_run     <= w_run_nxt;
            r_win     <= w_win_nxt;
            r_tmo     <= w_tmo_nxt;
        end
    end

    // Registered outputs; decode is gated by the lock state seen this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data   <= 8'h00;
            r_ctrl   <= 2'b00;
            r_de     <= 1'b0;
            r_locked <= 1'b0;
        end else begin
            r_locked <= (w_state_nxt == ST_LOCKED);
            if (r_state == ST_LOCKED) begin
                if (w_is_tok) begin
                    r_ctrl <= w_tok[1:0];
                    r_de   <= 1'b0;
                end else begin
                    r_data <= w_dec;
                    r_de   <= 1'b1;
                end
            end else begin
                r_de <= 1'b0;
            end
        end
    end

    assign data   = r_data;
    assign ctrl   = r_ctrl;
    assign de     = r_de;
    assign locked = r_locked;
    assign offset = r_offset;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Directed bench for tmds_channel_decoder: a word/bitstream-level model checked
// every cycle, plus hand-derived literal expectations at key points.
module tb_tmds_channel_decoder;

    localparam int SW = 1024;
    localparam int LR = 8;
    localparam int LT = 4096;

    localparam logic [9:0] TOK00 = 10'b1101010100;
    localparam logic [9:0] TOK01 = 10'b0010101011;
    // TOK00 stream delayed by three bits: {TOK00[6:0], TOK00[9:7]}
    localparam logic [9:0] ROT00 = 10'h2A6;
    // Stream that aligns to 10'h2FF at offset 3
    localparam logic [9:0] ROT2FF = 10'h3FD;

    logic       clk;
    logic       rst_n;
    logic [9:0] symbol_in;
    logic [7:0] data;
    logic [1:0] ctrl;
    logic       de;
    logic       locked;
    logic [3:0] offset;

    int n_checks;
    int n_errors;
    bit chk_en;

    int m_prev, m_word, m_offset, m_streak, m_dwell, m_silence;
    int m_data, m_ctrl, m_de, m_locked;

    tmds_channel_decoder #(
        .search_window(SW),
        .lock_run     (LR),
        .lost_timeout (LT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .symbol_in(symbol_in),
        .data     (data),
        .ctrl     (ctrl),
        .de       (de),
        .locked   (locked),
        .offset   (offset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Index of the control token (0..3) or -1 for a data symbol.
    function automatic int ref_token(input int q);
        int toks [4];
        toks = '{'h354, 'h0AB, 'h154, 'h2AB};
        for (int k = 0; k < 4; k++) begin
            if (q == toks[k]) return k;
        end
        return -1;
    endfunction

    function automatic int ref_decode(input int q);
        int d, o, cur, prv, x;
        d = q & 255;
        if (((q >> 9) & 1) == 1) d = 255 - d;
        o = d & 1;
        for (int k = 1; k < 8; k++) begin
            cur = (d >> k) & 1;
            prv = (d >> (k - 1)) & 1;
            x   = cur ^ prv;
            if (((q >> 8) & 1) == 0) x = 1 - x;
            o = o | (x << k);
        end
        return o;
    endfunction

    task automatic model_reset();
        m_prev = 0; m_word = 0; m_offset = 0; m_streak = 0; m_dwell = 0; m_silence = 0;
        m_data = 0; m_ctrl = 0; m_de = 0; m_locked = 0;
    endtask

    // One pixel clock: w is the word on the wire at this edge.
    task automatic model_step(input int w);
        int t, nxt;
        t = ref_token(m_word);
        if (m_locked == 1) begin
            if (t >= 0) begin
                m_ctrl = t;
                m_de   = 0;
            end else begin
                m_data = ref_decode(m_word);
                m_de   = 1;
            end
        end else begin
            m_de = 0;
        end
        nxt = (((w << 10) | m_prev) >> m_offset) & 'h3FF;
        if (m_locked == 0) begin
            m_streak = (t >= 0) ? m_streak + 1 : 0;
            if (m_streak == LR) begin
                m_locked = 1; m_streak = 0; m_dwell = 0; m_silence = 0;
            end else if (m_dwell == SW - 1) begin
                m_offset = (m_offset + 1) % 10; m_dwell = 0; m_streak = 0;
            end else begin
                m_dwell++;
            end
        end else if (t >= 0) begin
            m_silence = 0;
        end else begin
            m_silence++;
            if (m_silence == LT) begin
                m_locked = 0; m_silence = 0; m_streak = 0; m_dwell = 0;
            end
        end
        m_word = nxt;
        m_prev = w;
    endtask

    task automatic tick(input logic [9:0] w);
        symbol_in = w;
        @(posedge clk);
        if (rst_n) model_step(int'(w));
        #1;
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("m_data",   int'(data),   m_data);
            check("m_ctrl",   int'(ctrl),   m_ctrl);
            check("m_de",     int'(de),     m_de);
            check("m_locked", int'(locked), m_locked);
            check("m_offset", int'(offset), m_offset);
        end
    end

    initial begin
        int lock_at;
        n_checks = 0; n_errors = 0; chk_en = 1'b0;
        rst_n = 1'b0; symbol_in = 10'd0;
        model_reset();

        repeat (4) tick(10'($urandom));
        chk_en = 1'b1;
        repeat (3) tick(10'($urandom));
        check("rst_data",   int'(data),   0);
        check("rst_ctrl",   int'(ctrl),   0);
        check("rst_de",     int'(de),     0);
        check("rst_locked", int'(locked), 0);
        check("rst_offset", int'(offset), 0);

        // Aligned token stream at offset 0.
        rst_n = 1'b1;
        lock_at = 0;
        for (int i = 1; i <= 20; i++) begin
            tick(TOK00);
            if (locked && lock_at == 0) lock_at = i;
            if (i <= LR + 1) check("prelock_low", int'(locked), 0);
        end
        check("lock_edge0", lock_at, LR + 2);
        check("lock_off0",  int'(offset), 0);
        check("lock_ctrl0", int'(ctrl), 0);
        check("lock_de0",   int'(de), 0);

        // Decode after lock, two edges of latency.
        tick(10'h2FF); tick(TOK00); tick(TOK00);
        check("dec_2ff_data", int'(data), 'hFE);
        check("dec_2ff_de",   int'(de), 1);
        tick(10'h100); tick(TOK01); tick(TOK01);
        check("dec_100_data", int'(data), 'h00);
        check("dec_100_de",   int'(de), 1);
        tick(TOK01);
        check("tok01_ctrl", int'(ctrl), 1);
        check("tok01_de",   int'(de), 0);
        check("tok01_data", int'(data), 'h00);

        // Loss of lock exactly lost_timeout cycles after the last token.
        for (int i = 1; i <= LT + 2; i++) begin
            tick(10'h100);
            if (i == LT + 1) check("unlock_hold", int'(locked), 1);
            if (i == LT + 2) begin
                check("unlock_fall", int'(locked), 0);
                check("unlock_off",  int'(offset), 0);
            end
        end
        for (int i = 1; i <= SW; i++) begin
            tick(10'h100);
            if (i == SW - 1) check("resrch_off0", int'(offset), 0);
            if (i == SW)     check("resrch_off1", int'(offset), 1);
        end

        // Reset, then the token stream delayed by three bits.
        rst_n = 1'b0;
        model_reset();
        tick(TOK00); tick(TOK00);
        rst_n = 1'b1;
        lock_at = 0;
        for (int i = 1; i <= 3 * SW + LR + 3; i++) begin
            tick(ROT00);
            if (locked && lock_at == 0) lock_at = i;
        end
        check("lock_edge3", lock_at, 3 * SW + LR + 1);
        check("lock_off3",  int'(offset), 3);
        check("lock_ctrl3", int'(ctrl), 0);
        repeat (4) tick(ROT2FF);
        check("off3_data", int'(data), 'hFE);
        check("off3_de",   int'(de), 1);

        // Asynchronous reset between edges while locked.
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("arst_locked", int'(locked), 0);
        check("arst_de",     int'(de), 0);
        check("arst_offset", int'(offset), 0);
        check("arst_data",   int'(data), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) tick(10'h100);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
